// File: rtl/alu.sv
// rtl/alu.sv - registered ALU with carry/borrow, zero and signed-overflow flags
module alu #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       SEL,
   output logic [WIDTH-1:0] OUT,
   output logic             CARRY,
   output logic             ZERO,
   output logic             OVF
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } op_e;

   // One extra bit on each arithmetic path captures carry-out / borrow.
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic             w_add_ovf;
   logic             w_sub_ovf;

   logic [WIDTH-1:0] w_result;
   logic             w_carry;
   logic             w_ovf;
   logic             w_zero;

   logic [WIDTH-1:0] r_out;
   logic             r_carry;
   logic             r_zero;
   logic             r_ovf;

   // Arithmetic datapath shared by ADD and SUB decode arms.
   always_comb begin
      w_sum     = {1'b0, A} + {1'b0, B};
      w_diff    = {1'b0, A} - {1'b0, B};
      // Same operand signs but result sign flips -> signed overflow on add.
      w_add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      // Differing operand signs and result sign differs from A -> overflow on subtract.
      w_sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
   end

   // Operation decode: result, carry/borrow/shift-out and overflow.
   always_comb begin
      w_result = '0;
      w_carry  = 1'b0;
      w_ovf    = 1'b0;
      case (op_e'(SEL))
         OP_ADD: begin
            w_result = w_sum[WIDTH-1:0];
            w_carry  = w_sum[WIDTH];
            w_ovf    = w_add_ovf;
         end
         OP_SUB: begin
            w_result = w_diff[WIDTH-1:0];
            // The borrow out of the widened subtract is set exactly when A < B unsigned.
            w_carry  = w_diff[WIDTH];
            w_ovf    = w_sub_ovf;
         end
         OP_AND: w_result = A & B;
         OP_OR:  w_result = A | B;
         OP_XOR: w_result = A ^ B;
         OP_NOT: w_result = ~A;
         OP_SHL: begin
            w_result = {A[WIDTH-2:0], 1'b0};
            w_carry  = A[WIDTH-1];
         end
         OP_SHR: begin
            w_result = {1'b0, A[WIDTH-1:1]};
            w_carry  = A[0];
         end
         default: begin
            w_result = '0;
            w_carry  = 1'b0;
            w_ovf    = 1'b0;
         end
      endcase
      // Zero flag derives from the same value that is registered, so it is never stale.
      w_zero = (w_result == '0);
   end

   // Result register: reset wins over enable, otherwise hold when EN is low.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_out   <= '0;
         r_carry <= 1'b0;
         r_zero  <= 1'b1;
         r_ovf   <= 1'b0;
      end else if (EN) begin
         r_out   <= w_result;
         r_carry <= w_carry;
         r_zero  <= w_zero;
         r_ovf   <= w_ovf;
      end
   end

   assign OUT   = r_out;
   assign CARRY = r_carry;
   assign ZERO  = r_zero;
   assign OVF   = r_ovf;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for alu
module tb_alu;

   logic       CLK;
   logic       RST;
   logic       EN;
   logic [3:0] A;
   logic [3:0] B;
   logic [2:0] SEL;
   logic [3:0] OUT;
   logic       CARRY;
   logic       ZERO;
   logic       OVF;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string      tag;
      logic [3:0] out;
      logic       carry;
      logic       zero;
      logic       ovf;
   } exp_t;

   exp_t sb[$];
   exp_t last;

   alu #(.WIDTH(4)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .EN    (EN),
      .A     (A),
      .B     (B),
      .SEL   (SEL),
      .OUT   (OUT),
      .CARRY (CARRY),
      .ZERO  (ZERO),
      .OVF   (OVF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour using signed/unsigned integer arithmetic.
   function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
      exp_t e;
      int ua, ub, sa, sb2, r, s;
      ua = int'(a);
      ub = int'(b);
      sa = (ua >= 8) ? ua - 16 : ua;
      sb2 = (ub >= 8) ? ub - 16 : ub;
      e.carry = 1'b0;
      e.ovf   = 1'b0;
      r = 0;
      case (sel)
         3'd0: begin r = ua + ub; e.carry = (r > 15); s = sa + sb2; e.ovf = (s > 7) || (s < -8); end
         3'd1: begin r = ua - ub; e.carry = (ua < ub); s = sa - sb2; e.ovf = (s > 7) || (s < -8); end
         3'd2: r = ua & ub;
         3'd3: r = ua | ub;
         3'd4: r = ua ^ ub;
         3'd5: r = 15 - ua;
         3'd6: begin r = ua * 2; e.carry = (ua >= 8); end
         default: begin r = ua / 2; e.carry = (ua % 2) == 1; end
      endcase
      e.out  = 4'(r & 15);
      e.zero = (e.out == 4'd0);
      e.tag  = "";
      return e;
   endfunction

   // Drive one cycle, push the expected post-edge outputs, then pop and compare.
   task automatic cycle(input logic rst, input logic en, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] sel, input string tag, input bit use_exp,
                        input logic [3:0] e_out, input logic e_c, input logic e_z, input logic e_o);
      exp_t e;
      exp_t got;
      RST = rst; EN = en; A = a; B = b; SEL = sel;
      if (rst) begin
         e.out = 4'd0; e.carry = 1'b0; e.zero = 1'b1; e.ovf = 1'b0;
      end else if (!en) begin
         e = last;
      end else if (use_exp) begin
         e.out = e_out; e.carry = e_c; e.zero = e_z; e.ovf = e_o;
      end else begin
         e = model(a, b, sel);
      end
      e.tag = tag;
      sb.push_back(e);
      last = e;
      @(posedge CLK);
      #1;
      got = sb.pop_front();
      check_eq({got.tag, ".out"},   32'(OUT),   32'(got.out));
      check_eq({got.tag, ".carry"}, 32'(CARRY), 32'(got.carry));
      check_eq({got.tag, ".zero"},  32'(ZERO),  32'(got.zero));
      check_eq({got.tag, ".ovf"},   32'(OVF),   32'(got.ovf));
   endtask

   initial begin
      RST = 1'b1; EN = 1'b0; A = 4'd0; B = 4'd0; SEL = 3'd0;
      #2;
      // Reset for two cycles, with EN low then high.
      cycle(1, 0, 4'h0, 4'h0, 3'd0, "rst0", 0, 0, 0, 0, 0);
      cycle(1, 1, 4'h7, 4'h7, 3'd0, "rst1", 0, 0, 0, 0, 0);

      // Basic ops back to back.
      cycle(0, 1, 4'b0101, 4'b0011, 3'd0, "add",  1, 4'b1000, 0, 0, 1);
      cycle(0, 1, 4'b0101, 4'b0011, 3'd1, "sub",  1, 4'b0010, 0, 0, 0);
      cycle(0, 1, 4'b0101, 4'b0011, 3'd2, "and",  1, 4'b0001, 0, 0, 0);
      cycle(0, 1, 4'b0101, 4'b0011, 3'd3, "or",   1, 4'b0111, 0, 0, 0);
      cycle(0, 1, 4'b0101, 4'b0011, 3'd4, "xor",  1, 4'b0110, 0, 0, 0);
      cycle(0, 1, 4'b0101, 4'b1111, 3'd5, "not",  1, 4'b1010, 0, 0, 0);
      cycle(0, 1, 4'b0101, 4'b1111, 3'd6, "shl",  1, 4'b1010, 0, 0, 0);
      cycle(0, 1, 4'b0101, 4'b0000, 3'd7, "shr",  1, 4'b0010, 1, 0, 0);

      // Boundaries.
      cycle(0, 1, 4'b1111, 4'b0001, 3'd0, "add_wrap",   1, 4'b0000, 1, 1, 0);
      cycle(0, 1, 4'b0011, 4'b0101, 3'd1, "sub_borrow", 1, 4'b1110, 1, 0, 0);
      cycle(0, 1, 4'b1000, 4'b0001, 3'd1, "sub_ovf",    1, 4'b0111, 0, 0, 1);
      cycle(0, 1, 4'b1000, 4'b0000, 3'd6, "shl_out",    1, 4'b0000, 1, 1, 0);

      // Hold with EN low while inputs change.
      cycle(0, 1, 4'b0110, 4'b0111, 3'd0, "pre_hold", 1, 4'b1101, 0, 0, 1);
      cycle(0, 0, 4'b1111, 4'b1111, 3'd0, "hold0", 0, 0, 0, 0, 0);
      cycle(0, 0, 4'b0000, 4'b0001, 3'd1, "hold1", 0, 0, 0, 0, 0);
      cycle(0, 0, 4'b1010, 4'b0101, 3'd7, "hold2", 0, 0, 0, 0, 0);

      // Reset beats a pending ADD; the ADD result must never appear.
      cycle(1, 1, 4'b0101, 4'b0011, 3'd0, "prio",      0, 0, 0, 0, 0);
      cycle(0, 0, 4'b0101, 4'b0011, 3'd0, "prio_hold", 0, 0, 0, 0, 0);

      // Random traffic against the reference model.
      for (int i = 0; i < 60; i++) begin
         logic rr, ee;
         rr = ($urandom_range(0, 15) == 0);
         ee = ($urandom_range(0, 3) != 0);
         cycle(rr, ee, 4'($urandom), 4'($urandom), 3'($urandom), $sformatf("rnd%0d", i), 0, 0, 0, 0, 0);
      end

      // Exhaustive sweep of every operand pair and op.
      for (int s = 0; s < 8; s++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
               cycle(0, 1, 4'(a), 4'(b), 3'(s), $sformatf("sw%0d_%0d_%0d", s, a, b), 0, 0, 0, 0, 0);

      check_eq("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
